// File: rtl/rv_pipeline_pkg.sv
// Shared definitions for the single-issue pipeline: widths, bubble encoding,
// fetch FSM states and the IF/ID bundle.
package rv_pipeline_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;

  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
    logic            valid;
  } if_id_t;

endpackage : rv_pipeline_pkg

// File: rtl/if_id_register.sv
// IF/ID pipeline register: squash inserts a bubble, load captures a fetched
// instruction, otherwise the contents hold.
module if_id_register #(
  parameter logic [rv_pipeline_pkg::ILEN-1:0] NOP_INSTR = rv_pipeline_pkg::NOP_INSTR
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             i_load,
  input  logic                             i_squash,
  input  logic [rv_pipeline_pkg::XLEN-1:0] i_pc,
  input  logic [rv_pipeline_pkg::ILEN-1:0] i_instr,
  output rv_pipeline_pkg::if_id_t          o_if_id
);
  import rv_pipeline_pkg::*;

  if_id_t r_if_id;

  // NOTE: async reset is in the sensitivity list so the register clears
  // without waiting for a clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_if_id <= '{pc: '0, instr: NOP_INSTR, valid: 1'b0};
    end else if (i_squash) begin
      // The PC field is left as-is; a bubble is identified by valid alone.
      r_if_id.instr <= NOP_INSTR;
      r_if_id.valid <= 1'b0;
    end else if (i_load) begin
      r_if_id <= '{pc: i_pc, instr: i_instr, valid: 1'b1};
    end
  end

  assign o_if_id = r_if_id;

endmodule : if_id_register

// File: rtl/instruction_fetch_unit.sv
// IF stage: owns the PC and fetch FSM (BOOT/RUN/HALT), drives the instruction
// memory address and feeds the IF/ID register.
module instruction_fetch_unit #(
  parameter logic [rv_pipeline_pkg::XLEN-1:0] RESET_PC   = 64'd0,
  parameter logic [rv_pipeline_pkg::XLEN-1:0] PC_STEP    = 64'd4,
  parameter logic [rv_pipeline_pkg::XLEN-1:0] IMEM_BYTES = 64'd16,
  parameter logic [rv_pipeline_pkg::ILEN-1:0] NOP_INSTR  = rv_pipeline_pkg::NOP_INSTR
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             Stall,
  input  logic                             BranchTaken,
  input  logic [rv_pipeline_pkg::XLEN-1:0] BranchTarget,
  input  logic [rv_pipeline_pkg::ILEN-1:0] Instruction,
  output logic [rv_pipeline_pkg::XLEN-1:0] InstructionAddress,
  output logic [rv_pipeline_pkg::XLEN-1:0] IF_ID_PC,
  output logic [rv_pipeline_pkg::ILEN-1:0] IF_ID_Instruction,
  output logic                             IF_ID_Valid,
  output logic                             FetchFault,
  output logic [31:0]                      FetchCount
);
  import rv_pipeline_pkg::*;

  fetch_state_e    r_state;
  fetch_state_e    w_next_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_next_pc;
  logic            r_fault;
  logic [31:0]     r_count;
  logic            w_pc_illegal;
  logic            w_load;
  logic            w_squash;
  logic            w_fault_set;
  logic            w_count_inc;
  if_id_t          w_if_id;

  assign w_pc_illegal = (r_pc[1:0] != 2'b00) || (r_pc >= IMEM_BYTES);

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_next_pc    = r_pc;
    w_load       = 1'b0;
    w_squash     = 1'b0;
    w_fault_set  = 1'b0;
    w_count_inc  = 1'b0;
    unique case (r_state)
      ST_BOOT: begin
        w_next_state = ST_RUN;
        if (BranchTaken) w_next_pc = BranchTarget;
      end
      ST_RUN: begin
        // Branch outranks the fault check: a bad target faults one edge later.
        if (BranchTaken) begin
          w_next_pc = BranchTarget;
          w_squash  = 1'b1;
        end else if (w_pc_illegal) begin
          w_next_state = ST_HALT;
          w_fault_set  = 1'b1;
          w_squash     = 1'b1;
        end else if (!Stall) begin
          w_next_pc   = r_pc + PC_STEP;
          w_load      = 1'b1;
          w_count_inc = 1'b1;
        end
      end
      ST_HALT: ;
      default: w_next_state = ST_HALT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the values sampled at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_BOOT;
      r_pc    <= RESET_PC;
      r_fault <= 1'b0;
      r_count <= '0;
    end else begin
      r_state <= w_next_state;
      r_pc    <= w_next_pc;
      if (w_fault_set) r_fault <= 1'b1;
      if (w_count_inc && (r_count != 32'hFFFF_FFFF)) r_count <= r_count + 32'd1;
    end
  end

  if_id_register #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk      (clk),
    .reset    (reset),
    .i_load   (w_load),
    .i_squash (w_squash),
    .i_pc     (r_pc),
    .i_instr  (Instruction),
    .o_if_id  (w_if_id)
  );

  assign InstructionAddress = r_pc;
  assign IF_ID_PC           = w_if_id.pc;
  assign IF_ID_Instruction  = w_if_id.instr;
  assign IF_ID_Valid        = w_if_id.valid;
  assign FetchFault         = r_fault;
  assign FetchCount         = r_count;

endmodule : instruction_fetch_unit

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a 16-byte combinational
// instruction memory model.
module tb_instruction_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        Stall;
  logic        BranchTaken;
  logic [63:0] BranchTarget;
  logic [31:0] Instruction;
  logic [63:0] InstructionAddress;
  logic [63:0] IF_ID_PC;
  logic [31:0] IF_ID_Instruction;
  logic        IF_ID_Valid;
  logic        FetchFault;
  logic [31:0] FetchCount;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [4];

  always #5 clk = ~clk;

  always_comb begin
    Instruction = 32'h0;
    if (InstructionAddress < 64'd16) Instruction = mem[InstructionAddress[3:2]];
  end

  instruction_fetch_unit dut (
    .clk                (clk),
    .reset              (reset),
    .Stall              (Stall),
    .BranchTaken        (BranchTaken),
    .BranchTarget       (BranchTarget),
    .Instruction        (Instruction),
    .InstructionAddress (InstructionAddress),
    .IF_ID_PC           (IF_ID_PC),
    .IF_ID_Instruction  (IF_ID_Instruction),
    .IF_ID_Valid        (IF_ID_Valid),
    .FetchFault         (FetchFault),
    .FetchCount         (FetchCount)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; Stall = 1'b0; BranchTaken = 1'b0; BranchTarget = '0;
    tick();
    reset = 1'b0;
  endtask

  task automatic expect_state(string name, logic [63:0] addr, logic [63:0] pc,
                              logic [31:0] instr, logic valid, logic fault,
                              logic [31:0] count);
    checks++;
    if (InstructionAddress !== addr || IF_ID_PC !== pc || IF_ID_Instruction !== instr ||
        IF_ID_Valid !== valid || FetchFault !== fault || FetchCount !== count) begin
      errors++;
      $display("FAIL %s: got addr=%0h pc=%0h instr=%h v=%b f=%b cnt=%0d, want addr=%0h pc=%0h instr=%h v=%b f=%b cnt=%0d",
               name, InstructionAddress, IF_ID_PC, IF_ID_Instruction, IF_ID_Valid,
               FetchFault, FetchCount, addr, pc, instr, valid, fault, count);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; Stall = 1'b0; BranchTaken = 1'b0; BranchTarget = '0;
    #2;
    expect_state("reset_values", 64'd0, 64'd0, NOP, 1'b0, 1'b0, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    expect_state("boot_cycle", 64'd0, 64'd0, NOP, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (InstructionAddress !== 64'(4 * i)) begin
        errors++;
        $display("FAIL seq_addr[%0d]: got %0h want %0h", i, InstructionAddress, 4 * i);
      end
      tick();
      expect_state($sformatf("seq_capture[%0d]", i), 64'(4 * (i + 1)), 64'(4 * i),
                   mem[i], 1'b1, 1'b0, 32'(i + 1));
    end
  endtask

  task automatic test_end_of_memory();
    tick();
    expect_state("eom_halt", 64'd16, 64'd12, NOP, 1'b0, 1'b1, 32'd4);
    BranchTaken = 1'b1; BranchTarget = 64'd0;
    tick();
    tick();
    BranchTaken = 1'b0;
    expect_state("halt_frozen", 64'd16, 64'd12, NOP, 1'b0, 1'b1, 32'd4);
  endtask

  task automatic test_stall();
    do_reset();
    tick(); tick(); tick();
    expect_state("pre_stall", 64'd8, 64'd4, mem[1], 1'b1, 1'b0, 32'd2);
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_state($sformatf("stall_hold[%0d]", i), 64'd8, 64'd4, mem[1], 1'b1, 1'b0, 32'd2);
    end
    Stall = 1'b0;
    tick();
    expect_state("stall_resume", 64'd12, 64'd8, mem[2], 1'b1, 1'b0, 32'd3);
  endtask

  task automatic test_branch_with_stall();
    BranchTaken = 1'b1; BranchTarget = 64'd4; Stall = 1'b1;
    tick();
    BranchTaken = 1'b0; Stall = 1'b0;
    expect_state("branch_squash", 64'd4, 64'd8, NOP, 1'b0, 1'b0, 32'd3);
    tick();
    expect_state("branch_target_capture", 64'd8, 64'd4, mem[1], 1'b1, 1'b0, 32'd4);
  endtask

  task automatic test_misaligned();
    BranchTaken = 1'b1; BranchTarget = 64'd6;
    tick();
    BranchTaken = 1'b0;
    expect_state("misaligned_loaded", 64'd6, 64'd4, NOP, 1'b0, 1'b0, 32'd4);
    tick();
    expect_state("misaligned_halt", 64'd6, 64'd4, NOP, 1'b0, 1'b1, 32'd4);
  endtask

  task automatic test_async_reset();
    do_reset();
    tick(); tick(); tick();
    expect_state("pre_async", 64'd8, 64'd4, mem[1], 1'b1, 1'b0, 32'd2);
    #2 reset = 1'b1;
    #1;
    expect_state("async_reset_immediate", 64'd0, 64'd0, NOP, 1'b0, 1'b0, 32'd0);
    #1 reset = 1'b0;
    tick();
    expect_state("async_boot", 64'd0, 64'd0, NOP, 1'b0, 1'b0, 32'd0);
    tick();
    expect_state("async_first_capture", 64'd4, 64'd0, mem[0], 1'b1, 1'b0, 32'd1);
  endtask

  task automatic test_boot_branch();
    do_reset();
    BranchTaken = 1'b1; BranchTarget = 64'd8;
    tick();
    BranchTaken = 1'b0;
    expect_state("boot_branch", 64'd8, 64'd0, NOP, 1'b0, 1'b0, 32'd0);
    tick();
    expect_state("boot_branch_capture", 64'd12, 64'd8, mem[2], 1'b1, 1'b0, 32'd1);
  endtask

  task automatic test_out_of_range_target();
    BranchTaken = 1'b1; BranchTarget = 64'd32;
    tick();
    BranchTaken = 1'b0;
    tick();
    expect_state("range_halt", 64'd32, 64'd8, NOP, 1'b0, 1'b1, 32'd1);
  endtask

  initial begin
    mem[0] = 32'h0010_0093;
    mem[1] = 32'h0020_0113;
    mem[2] = 32'h0031_8193;
    mem[3] = 32'h4020_8233;
    test_reset();
    test_sequential();
    test_end_of_memory();
    test_stall();
    test_branch_with_stall();
    test_misaligned();
    test_async_reset();
    test_boot_branch();
    test_out_of_range_target();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_instruction_fetch_unit

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- IF stage of the 64-bit single-issue pipeline, directly upstream of Instruction_Memory.
- Holds the PC and drives InstructionAddress.
- Captures the returned 32-bit Instruction into the IF/ID pipeline register.
- Handles stall, branch redirect with squash, and halts on an illegal fetch address.

Parameters:
- RESET_PC, 64'd0, PC value loaded on reset.
- PC_STEP, 64'd4, sequential PC increment in bytes.
- IMEM_BYTES, 64'd16, instruction memory size in bytes; a PC >= IMEM_BYTES is illegal.
- NOP_INSTR, 32'h00000013, bubble encoding (addi x0,x0,0) placed in IF/ID on squash or invalid.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- Stall  in  1  hazard stall; hold PC and IF/ID
- BranchTaken  in  1  redirect request from EX
- BranchTarget  in  64  redirect PC
- Instruction  in  32  combinational read data from Instruction_Memory
- InstructionAddress  out  64  current PC, to Instruction_Memory
- IF_ID_PC  out  64  PC of the captured instruction
- IF_ID_Instruction  out  32  captured instruction
- IF_ID_Valid  out  1  IF/ID holds a real instruction
- FetchFault  out  1  sticky; illegal PC detected
- FetchCount  out  32  number of instructions captured, saturating

Behaviour:
- One clock, clk; reset is asynchronous and active-high, port reset.
- InstructionAddress = PC register, combinationally.
- Instruction memory is combinational, so there is a 1-cycle fetch latency: PC at cycle n appears in IF/ID after edge n.
- Reset values:
  - PC = RESET_PC; IF_ID_PC = 0; IF_ID_Instruction = NOP_INSTR; IF_ID_Valid = 0.
  - FetchFault = 0; FetchCount = 0; state = BOOT.
- States:
  - BOOT: one cycle after reset release. IF/ID stays invalid. PC unchanged. Next state is RUN.
  - RUN: normal fetch.
  - HALT: PC frozen, IF_ID_Valid = 0, FetchFault = 1. Only reset exits HALT.
- Priority at each posedge in RUN: reset (async) > BranchTaken > illegal-PC check > Stall > sequential fetch.
- Branch (BranchTaken = 1):
  - PC <= BranchTarget.
  - IF_ID_Valid <= 0 and IF_ID_Instruction <= NOP_INSTR (squash).
  - Overrides Stall in the same cycle.
  - FetchCount unchanged.
- Illegal PC is PC[1:0] != 0 or PC >= IMEM_BYTES.
  - Checked when not branching, including while stalled.
  - On detection: go to HALT, FetchFault <= 1, IF_ID_Valid <= 0, IF/ID instruction <= NOP_INSTR.
  - A misaligned or out-of-range BranchTarget is loaded, then faults on the following edge.
- Stall (no branch): PC, IF/ID and FetchCount all hold.
- Sequential fetch:
  - IF_ID_PC <= PC, IF_ID_Instruction <= Instruction, IF_ID_Valid <= 1.
  - PC <= PC + PC_STEP, with 64-bit wrap (wrap is unreachable before the fault).
  - FetchCount <= FetchCount + 1, saturating at 32'hFFFFFFFF.
- In BOOT, BranchTaken is honoured: PC is redirected and the state still moves to RUN.
- Reset asserted mid-operation returns every output to its reset value immediately, regardless of clock.

Decomposition:
- Shared package (rv_pipeline_pkg):
  - constants XLEN = 64, ILEN = 32, NOP_INSTR.
  - fetch state encoding: BOOT, RUN, HALT.
  - IF/ID bundle typedef: pc, instr, valid.
- One natural sub-module: if_id_register, the IF/ID pipeline register with hold and squash controls. The PC/next-PC logic and FSM stay in the top module.
- Instruction_Memory is instantiated alongside this block by the top level, not inside it.

Test Plan:
- Sequential fetch: IMEM_BYTES = 16, preload words at 0, 4, 8, 12. After reset, InstructionAddress steps 0, 4, 8, 12 on successive cycles. IF/ID shows PC 0, 4, 8, 12 with matching words one cycle later. FetchCount = 4.
- End of memory: continue the sequential run. PC = 16 leads to HALT on the next edge: FetchFault = 1, IF_ID_Valid = 0, InstructionAddress frozen at 16.
- Stall: assert Stall for 3 cycles at PC = 8. PC stays 8; IF/ID holds PC 4's instruction with valid = 1; FetchCount is unchanged. After release, fetch resumes at 8.
- Branch with stall: BranchTaken = 1, BranchTarget = 4, Stall = 1 at PC = 12. Next cycle PC = 4, IF_ID_Valid = 0, IF_ID_Instruction = 32'h00000013. One cycle later, IF/ID holds PC 4.
- Misaligned target: BranchTarget = 6. PC = 6 for one cycle, then HALT with FetchFault = 1.
- Async reset mid-run: pulse reset between clock edges while PC = 8. Immediately PC = 0, IF_ID_Valid = 0, FetchCount = 0. First capture (PC 0) occurs on the second edge after release, because of BOOT.
